// File: rtl/ysyx_23060072_clint_pkg.sv
// Shared constants for the CLINT machine timer: register offsets inside the
// 32-byte window, CTRL bit positions and the default window base.
// The MSIP offset is only decoded when CLINT_MSIP_EN is defined.
package ysyx_23060072_clint_pkg;

  localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_PRESC       = 5'h14;
  localparam logic [4:0] OFF_MSIP        = 5'h18;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_IRQ_EN = 1;

  // True when addr falls inside the 32-byte window starting at base.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:5] == base[31:5];
  endfunction

endpackage

// File: rtl/ysyx_23060072_clint_prescaler.sv
// Prescaler for the CLINT timer: counts enabled cycles and emits a tick on the
// cycle its count matches the reload value, then restarts from zero.
module ysyx_23060072_clint_prescaler
  import ysyx_23060072_clint_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cnt_en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // Tick is combinational so mtime advances in the same cycle the count matches.
  assign tick_o = cnt_en_i && (cnt_q == presc_i);

  // Next count: a reload write wins, then wrap on tick, else count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_23060072_clint_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled counting,
// registered level interrupt and a single-beat bus with a one-cycle response.
// Optional MSIP register and soft_interrupt_o port under CLINT_MSIP_EN.
module ysyx_23060072_clint_timer
  import ysyx_23060072_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = CLINT_BASE_ADDR,
  parameter int          PRESC_W   = 16,
  parameter logic [63:0] RST_CMP   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rsp_o,
  output logic        timer_interrupt_o
`ifdef CLINT_MSIP_EN
  ,
  output logic        soft_interrupt_o
`endif
);

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        hi_shadow_q, hi_shadow_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rsp_q;
  logic               irq_q, irq_d;
  logic               tick;
  logic               hit;
  logic               wr_hit;
  logic               rd_hit;
  logic [4:0]         offset;
  logic [31:0]        rd_val;
`ifdef CLINT_MSIP_EN
  logic               msip_q, msip_d;
`endif

  // Only word-aligned addresses inside the window are decoded.
  assign offset = addr_i[4:0];
  assign hit    = in_window(addr_i, BASE_ADDR) && (addr_i[1:0] == 2'b00);
  assign wr_hit = en_i && we_i && hit;
  assign rd_hit = en_i && !we_i && hit;

  ysyx_23060072_clint_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .cnt_en_i (ctrl_q[CTRL_CNT_EN]),
    .clr_i    (wr_hit && (offset == OFF_PRESC)),
    .presc_i  (presc_q),
    .tick_o   (tick)
  );

  // Read mux over the register map; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (offset)
        OFF_MTIME_LO:    rd_val = mtime_q[31:0];
        OFF_MTIME_HI:    rd_val = hi_shadow_q;
        OFF_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
        OFF_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
        OFF_CTRL:        rd_val = {30'b0, ctrl_q};
        OFF_PRESC:       rd_val = 32'(presc_q);
`ifdef CLINT_MSIP_EN
        OFF_MSIP:        rd_val = {31'b0, msip_q};
`endif
        default:         rd_val = '0;
      endcase
    end
  end

  // Register next state: a bus write to either mtime half replaces that half
  // and suppresses the tick increment for the cycle.
  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    ctrl_d      = ctrl_q;
    presc_d     = presc_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = rdata_q;
`ifdef CLINT_MSIP_EN
    msip_d      = msip_q;
`endif
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_hit) begin
      case (offset)
        OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], wdata_i};
        OFF_MTIME_HI:    mtime_d = {wdata_i, mtime_q[31:0]};
        OFF_MTIMECMP_LO: mtimecmp_d[31:0] = wdata_i;
        OFF_MTIMECMP_HI: mtimecmp_d[63:32] = wdata_i;
        OFF_CTRL:        ctrl_d = wdata_i[1:0];
        OFF_PRESC:       presc_d = wdata_i[PRESC_W-1:0];
`ifdef CLINT_MSIP_EN
        OFF_MSIP:        msip_d = wdata_i[0];
`endif
        default:         ;
      endcase
    end
    if (en_i && !we_i) begin
      rdata_d = rd_val;
    end
    if (rd_hit && (offset == OFF_MTIME_LO)) begin
      hi_shadow_d = mtime_q[63:32];
    end
    irq_d = ctrl_q[CTRL_IRQ_EN] && (mtime_q >= mtimecmp_q);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= RST_CMP;
      ctrl_q      <= '0;
      presc_q     <= '0;
      hi_shadow_q <= '0;
      rdata_q     <= '0;
      rsp_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      ctrl_q      <= ctrl_d;
      presc_q     <= presc_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      rsp_q       <= en_i;
      irq_q       <= irq_d;
    end
  end

`ifdef CLINT_MSIP_EN
  // Software interrupt pending bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
    end
  end

  assign soft_interrupt_o = msip_q;
`endif

  assign rdata_o           = rdata_q;
  assign rsp_o             = rsp_q;
  assign timer_interrupt_o = irq_q;

endmodule
